fp_mant_normalize: RTL and testbench

//  Downstream stage of the FP adder's mantissa add/subtract. Takes the 25-bit unsigned magnitude sum,
//  the pre-aligned exponent and the result sign, then normalizes to hidden-bit-at-23 with a multi-cycle

---
 rtl/fp_pkg.sv | 19 +
 rtl/lzc24.sv | 17 +
 rtl/fp_mant_normalize.sv | 139 +++++++++++++
 tb/tb_fp_mant_normalize.sv | 136 +++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared FP constants, normalizer FSM state encodings and flag bit positions.
package fp_pkg;

    localparam int unsigned FP_EXP_W  = 8;
    localparam int unsigned FP_FRAC_W = 23;
    localparam int unsigned FP_BIAS   = 127;

    localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = 8'hFF;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] NORM = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Bit positions inside the {ovf, unf, zero} flag word
    localparam int unsigned FLAG_ZERO = 0;
    localparam int unsigned FLAG_UNF  = 1;
    localparam int unsigned FLAG_OVF  = 2;

endpackage

// File: rtl/lzc24.sv
// Combinational 24-bit leading-zero counter; reports 24 for an all-zero input.
module lzc24 (
    input  logic [23:0] value,
    output logic [4:0]  count
);

    always_comb begin
        count = 5'd24;
        // Ascending scan so the highest set bit is the last to win
        for (int i = 0; i < 24; i++) begin
            if (value[i]) begin
                count = 5'(23 - i);
            end
        end
    end

endmodule

// File: rtl/fp_mant_normalize.sv
// Mantissa normalizer and IEEE-754 single packer with a multi-cycle limited left shifter.
// Define FP_NORM_FLAGS_EN to add the registered {ovf, unf, zero} out_flags port.
module fp_mant_normalize
    import fp_pkg::*;
#(
    parameter int unsigned MAX_SHIFT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [24:0] in_mant,
    input  logic [7:0]  in_exp,
    input  logic        in_sign,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result
`ifdef FP_NORM_FLAGS_EN
   ,output logic [2:0]  out_flags
`endif
);

    localparam logic [4:0] MaxShiftW = 5'(MAX_SHIFT);

    logic [1:0]        state_q, state_d;
    logic [24:0]       m_q, m_d;
    logic signed [9:0] e_q, e_d;
    logic              s_q, s_d;
    logic [31:0]       res_q, res_d;

    logic [4:0]        lz;
    logic [4:0]        k;
    logic signed [9:0] e_inc;
    logic signed [9:0] e_sub;

`ifdef FP_NORM_FLAGS_EN
    logic [2:0] flags_q, flags_d;
    assign out_flags = flags_q;
`endif

    lzc24 u_lzc (
        .value (m_q[23:0]),
        .count (lz)
    );

    assign k     = (lz < MaxShiftW) ? lz : MaxShiftW;
    assign e_inc = e_q + 10'sd1;
    assign e_sub = e_q - $signed({5'b0, k});

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        e_d     = e_q;
        s_d     = s_q;
        res_d   = res_q;
`ifdef FP_NORM_FLAGS_EN
        flags_d = flags_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    m_d     = in_mant;
                    e_d     = $signed({2'b00, in_exp});
                    s_d     = in_sign;
                    state_d = NORM;
`ifdef FP_NORM_FLAGS_EN
                    flags_d = '0;
`endif
                end
            end
            NORM: begin
                if (m_q == '0) begin
                    res_d   = '0;
                    state_d = DONE;
`ifdef FP_NORM_FLAGS_EN
                    flags_d[FLAG_ZERO] = 1'b1;
`endif
                end else if (m_q[24]) begin
                    // Carry out: one right shift, the dropped LSB is simply truncated
                    state_d = DONE;
                    if (e_inc >= $signed({2'b00, FP_EXP_MAX})) begin
                        res_d = {s_q, FP_EXP_MAX, {FP_FRAC_W{1'b0}}};
`ifdef FP_NORM_FLAGS_EN
                        flags_d[FLAG_OVF] = 1'b1;
`endif
                    end else begin
                        res_d = {s_q, e_inc[FP_EXP_W-1:0], m_q[FP_FRAC_W:1]};
                    end
                end else if (m_q[23]) begin
                    res_d   = {s_q, e_q[FP_EXP_W-1:0], m_q[FP_FRAC_W-1:0]};
                    state_d = DONE;
                end else if (e_sub <= 10'sd0) begin
                    // Flush to zero; no denormal support, sign is preserved
                    res_d   = {s_q, 31'h0};
                    state_d = DONE;
`ifdef FP_NORM_FLAGS_EN
                    flags_d[FLAG_UNF] = 1'b1;
`endif
                end else begin
                    m_d = m_q << k;
                    e_d = e_sub;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            e_q     <= '0;
            s_q     <= 1'b0;
            res_q   <= '0;
`ifdef FP_NORM_FLAGS_EN
            flags_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            e_q     <= e_d;
            s_q     <= s_d;
            res_q   <= res_d;
`ifdef FP_NORM_FLAGS_EN
            flags_q <= flags_d;
`endif
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_result = res_q;

endmodule

// File: tb/tb_fp_mant_normalize.sv
// Directed self-checking bench for fp_mant_normalize (MAX_SHIFT = 4).
module tb_fp_mant_normalize;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] in_mant;
    logic [7:0]  in_exp;
    logic        in_sign;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
`ifdef FP_NORM_FLAGS_EN
    logic [2:0]  out_flags;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    fp_mant_normalize #(
        .MAX_SHIFT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mant    (in_mant),
        .in_exp     (in_exp),
        .in_sign    (in_sign),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
`ifdef FP_NORM_FLAGS_EN
       ,.out_flags  (out_flags)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic [2:0] exp);
`ifdef FP_NORM_FLAGS_EN
        check({tag, " flags"}, {37'b0, out_flags}, {37'b0, exp});
`else
        if (exp === 3'bxxx) $display("unused %s", tag);
`endif
    endtask

    // Called one time unit after a rising edge with the DUT idle
    task automatic run_job(input string tag, input logic [24:0] mant, input logic [7:0] exp,
                           input logic sgn, input logic [31:0] exp_res, input int exp_lat,
                           input logic [2:0] exp_flags, input int hold);
        int lat;
        in_mant  = mant;
        in_exp   = exp;
        in_sign  = sgn;
        in_valid = 1'b1;
        check({tag, " in_ready"}, {39'b0, in_ready}, 40'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 40'(lat), 40'(exp_lat));
        check({tag, " result"}, {8'b0, out_result}, {8'b0, exp_res});
        check_flags(tag, exp_flags);
        repeat (hold) begin
            @(posedge clk); #1;
            check({tag, " stall"}, {6'b0, in_ready, out_valid, out_result},
                  {6'b0, 1'b0, 1'b1, exp_res});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " release"}, {38'b0, out_valid, in_ready}, 40'b01);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mant   = '0;
        in_exp    = '0;
        in_sign   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", {6'b0, in_ready, out_valid, out_result}, {6'b0, 1'b1, 1'b0, 32'h0});
        check_flags("reset", 3'b000);
        rst = 1'b0;
        @(posedge clk); #1;

        run_job("norm",      25'h0C00000, 8'h7F, 1'b0, 32'h3FC00000, 2, 3'b000, 0);
        run_job("carry",     25'h1800000, 8'h7F, 1'b0, 32'h40400000, 2, 3'b000, 0);
        run_job("shift23",   25'h0000001, 8'h7F, 1'b0, 32'h34000000, 8, 3'b000, 0);
        run_job("zero",      25'h0000000, 8'h7F, 1'b1, 32'h00000000, 2, 3'b001, 0);
        run_job("ovf",       25'h1000000, 8'hFE, 1'b0, 32'h7F800000, 2, 3'b100, 0);
        run_job("unf",       25'h0000001, 8'h05, 1'b0, 32'h00000000, 3, 3'b010, 0);
        run_job("unf_neg",   25'h0000001, 8'h05, 1'b1, 32'h80000000, 3, 3'b010, 0);
        run_job("neg_norm",  25'h0800000, 8'h80, 1'b1, 32'hC0000000, 2, 3'b000, 0);
        run_job("shift2",    25'h0200000, 8'h7F, 1'b0, 32'h3E800000, 3, 3'b000, 0);
        run_job("carry_trn", 25'h1FFFFFF, 8'h7F, 1'b0, 32'h407FFFFF, 2, 3'b000, 0);
        run_job("stall",     25'h0C00000, 8'h7F, 1'b0, 32'h3FC00000, 2, 3'b000, 5);

        // Reset while the shifter is mid-way through a long normalization
        in_mant  = 25'h0000001;
        in_exp   = 8'h7F;
        in_sign  = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid", {6'b0, in_ready, out_valid, out_result}, {6'b0, 1'b1, 1'b0, 32'h0});
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("rst_drop", {38'b0, in_ready, out_valid}, 40'b10);

        run_job("post_rst",  25'h1800000, 8'h7F, 1'b0, 32'h40400000, 2, 3'b000, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
